// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, R-type functs, ALU ops, selector kinds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam int REG_LINK = 31;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [1:0] {S1_RS, S1_RT, S1_ZERO, S1_PC4} src1_sel_t;
  typedef enum logic [2:0] {S2_RT, S2_SEXT, S2_ZEXT, S2_LUI, S2_SHAMT, S2_RS, S2_ZERO} src2_sel_t;
  typedef enum logic [1:0] {WSEL_RD, WSEL_RT, WSEL_LINK} wsel_t;
  typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_J, BR_JR} br_kind_t;

endpackage

// File: rtl/inst_decoder.sv
// Combinational decode of opcode/funct into control, operand selects, source-use and branch kind.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow the inputs.
// Ports: op, funct in; aluop, src1_sel, src2_sel, wsel, use_rs, use_rt, wreg, mem_rd, mem_wr, illegal, br_kind out.
module inst_decoder
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output alu_op_t    aluop,
  output src1_sel_t  src1_sel,
  output src2_sel_t  src2_sel,
  output wsel_t      wsel,
  output logic       use_rs,
  output logic       use_rt,
  output logic       wreg,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       illegal,
  output br_kind_t   br_kind
);

  always_comb begin
    aluop    = ALU_ADD;
    src1_sel = S1_RS;
    src2_sel = S2_RT;
    wsel     = WSEL_RT;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    wreg     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    illegal  = 1'b0;
    br_kind  = BR_NONE;
    case (op)
      OP_RTYPE: begin
        wsel   = WSEL_RD;
        wreg   = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
        case (funct)
          // Shifts operate on rt; the amount comes from shamt or rs[4:0].
          F_SLL:  begin aluop = ALU_SLL; src1_sel = S1_RT; src2_sel = S2_SHAMT; use_rs = 1'b0; end
          F_SRL:  begin aluop = ALU_SRL; src1_sel = S1_RT; src2_sel = S2_SHAMT; use_rs = 1'b0; end
          F_SRA:  begin aluop = ALU_SRA; src1_sel = S1_RT; src2_sel = S2_SHAMT; use_rs = 1'b0; end
          F_SLLV: begin aluop = ALU_SLL; src1_sel = S1_RT; src2_sel = S2_RS; end
          F_SRLV: begin aluop = ALU_SRL; src1_sel = S1_RT; src2_sel = S2_RS; end
          F_SRAV: begin aluop = ALU_SRA; src1_sel = S1_RT; src2_sel = S2_RS; end
          F_JR:   begin wreg = 1'b0; use_rt = 1'b0; br_kind = BR_JR; end
          // Link value pc+4 travels to EX as src1 + 0.
          F_JALR: begin use_rt = 1'b0; br_kind = BR_JR; src1_sel = S1_PC4; src2_sel = S2_ZERO; end
          F_ADD, F_ADDU: aluop = ALU_ADD;
          F_SUB, F_SUBU: aluop = ALU_SUB;
          F_AND:  aluop = ALU_AND;
          F_OR:   aluop = ALU_OR;
          F_XOR:  aluop = ALU_XOR;
          F_NOR:  aluop = ALU_NOR;
          F_SLT:  aluop = ALU_SLT;
          F_SLTU: aluop = ALU_SLTU;
          default: begin illegal = 1'b1; wreg = 1'b0; use_rs = 1'b0; use_rt = 1'b0; end
        endcase
      end
      OP_J:    br_kind = BR_J;
      OP_JAL:  begin br_kind = BR_J; wreg = 1'b1; wsel = WSEL_LINK; src1_sel = S1_PC4; src2_sel = S2_ZERO; end
      OP_BEQ:  begin br_kind = BR_BEQ;  use_rs = 1'b1; use_rt = 1'b1; end
      OP_BNE:  begin br_kind = BR_BNE;  use_rs = 1'b1; use_rt = 1'b1; end
      OP_BLEZ: begin br_kind = BR_BLEZ; use_rs = 1'b1; end
      OP_BGTZ: begin br_kind = BR_BGTZ; use_rs = 1'b1; end
      OP_ADDI, OP_ADDIU: begin use_rs = 1'b1; wreg = 1'b1; src2_sel = S2_SEXT; end
      OP_SLTI:  begin aluop = ALU_SLT;  use_rs = 1'b1; wreg = 1'b1; src2_sel = S2_SEXT; end
      OP_SLTIU: begin aluop = ALU_SLTU; use_rs = 1'b1; wreg = 1'b1; src2_sel = S2_SEXT; end
      OP_ANDI:  begin aluop = ALU_AND;  use_rs = 1'b1; wreg = 1'b1; src2_sel = S2_ZEXT; end
      OP_ORI:   begin aluop = ALU_OR;   use_rs = 1'b1; wreg = 1'b1; src2_sel = S2_ZEXT; end
      OP_XORI:  begin aluop = ALU_XOR;  use_rs = 1'b1; wreg = 1'b1; src2_sel = S2_ZEXT; end
      OP_LUI:   begin wreg = 1'b1; src1_sel = S1_ZERO; src2_sel = S2_LUI; end
      OP_LW:    begin use_rs = 1'b1; wreg = 1'b1; mem_rd = 1'b1; src2_sel = S2_SEXT; end
      OP_SW:    begin use_rs = 1'b1; use_rt = 1'b1; mem_wr = 1'b1; src2_sel = S2_SEXT; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: reads/forwards operands, resolves branches/jumps, holds one decoded instruction.
// Latency: 1 cycle from accept to ex_valid; redirect is registered and follows the accept by 1 cycle.
// Backpressure: if_ready drops while the held slot is blocked by ex_ready, on a data hazard, or on flush.
// Ports: fetch (if_*), register file (rf_*), EX/MEM result taps (*_fwd_*), execute (ex_*), flush, redirect.
// Build option: ID_FORWARD_EN enables EX/MEM forwarding; without it any pending EX/MEM write to a source stalls.
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [31:0]        if_inst,
  input  logic [DATA_W-1:0]  if_pc,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  input  logic               ex_fwd_wen,
  input  logic               ex_fwd_load,
  input  logic [RADDR_W-1:0] ex_fwd_waddr,
  input  logic [DATA_W-1:0]  ex_fwd_wdata,
  input  logic               mem_fwd_wen,
  input  logic [RADDR_W-1:0] mem_fwd_waddr,
  input  logic [DATA_W-1:0]  mem_fwd_wdata,
  output logic               ex_valid,
  input  logic               ex_ready,
  output alu_op_t            ex_aluop,
  output logic [DATA_W-1:0]  ex_src1,
  output logic [DATA_W-1:0]  ex_src2,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [RADDR_W-1:0] ex_waddr,
  output logic               ex_wreg,
  output logic               ex_mem_rd,
  output logic               ex_mem_wr,
  output logic               ex_illegal,
  input  logic               flush,
  output logic               redirect,
  output logic [DATA_W-1:0]  redirect_pc
);

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;

  alu_op_t   aluop;
  src1_sel_t src1_sel;
  src2_sel_t src2_sel;
  wsel_t     wsel;
  br_kind_t  br_kind;
  logic use_rs, use_rt, wreg, mem_rd, mem_wr, illegal;

  inst_decoder u_dec (
    .op(if_inst[31:26]), .funct(if_inst[5:0]),
    .aluop(aluop), .src1_sel(src1_sel), .src2_sel(src2_sel), .wsel(wsel),
    .use_rs(use_rs), .use_rt(use_rt), .wreg(wreg), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .illegal(illegal), .br_kind(br_kind)
  );

  assign rf_raddr1 = RADDR_W'(if_inst[25:21]);
  assign rf_raddr2 = RADDR_W'(if_inst[20:16]);

  // Address matches against in-flight writers; r0 never matches.
  logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  assign rs_ex_hit  = ex_fwd_wen  && ex_fwd_waddr  != '0 && ex_fwd_waddr  == rf_raddr1;
  assign rt_ex_hit  = ex_fwd_wen  && ex_fwd_waddr  != '0 && ex_fwd_waddr  == rf_raddr2;
  assign rs_mem_hit = mem_fwd_wen && mem_fwd_waddr != '0 && mem_fwd_waddr == rf_raddr1;
  assign rt_mem_hit = mem_fwd_wen && mem_fwd_waddr != '0 && mem_fwd_waddr == rf_raddr2;

  logic              hazard;
  logic [DATA_W-1:0] op1, op2;

`ifdef ID_FORWARD_EN
  // Only a load in EX cannot be forwarded yet.
  assign hazard = ex_fwd_load && ((use_rs && rs_ex_hit) || (use_rt && rt_ex_hit));
  assign op1 = (rf_raddr1 == '0) ? '0 :
               (rs_ex_hit && !ex_fwd_load) ? ex_fwd_wdata :
               rs_mem_hit ? mem_fwd_wdata : rf_rdata1;
  assign op2 = (rf_raddr2 == '0) ? '0 :
               (rt_ex_hit && !ex_fwd_load) ? ex_fwd_wdata :
               rt_mem_hit ? mem_fwd_wdata : rf_rdata2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd_wdata, mem_fwd_wdata, ex_fwd_load};
  assign hazard = (use_rs && (rs_ex_hit || rs_mem_hit)) || (use_rt && (rt_ex_hit || rt_mem_hit));
  assign op1 = (rf_raddr1 == '0) ? '0 : rf_rdata1;
  assign op2 = (rf_raddr2 == '0) ? '0 : rf_rdata2;
`endif

  logic [DATA_W-1:0] pc4, imm_sext, src1, src2, target;
  logic [RADDR_W-1:0] waddr;
  logic taken;

  assign pc4      = if_pc + DATA_W'(4);
  assign imm_sext = {{(DATA_W-16){if_inst[15]}}, if_inst[15:0]};

  always_comb begin
    case (src1_sel)
      S1_RS:   src1 = op1;
      S1_RT:   src1 = op2;
      S1_PC4:  src1 = pc4;
      default: src1 = '0;
    endcase
    case (src2_sel)
      S2_RT:    src2 = op2;
      S2_SEXT:  src2 = imm_sext;
      S2_ZEXT:  src2 = {{(DATA_W-16){1'b0}}, if_inst[15:0]};
      S2_LUI:   src2 = {if_inst[15:0], {(DATA_W-16){1'b0}}};
      S2_SHAMT: src2 = DATA_W'(if_inst[10:6]);
      S2_RS:    src2 = DATA_W'(op1[4:0]);
      default:  src2 = '0;
    endcase
    case (wsel)
      WSEL_RD:   waddr = RADDR_W'(if_inst[15:11]);
      WSEL_LINK: waddr = RADDR_W'(REG_LINK);
      default:   waddr = RADDR_W'(if_inst[20:16]);
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = pc4 + {imm_sext[DATA_W-3:0], 2'b00};
    case (br_kind)
      BR_BEQ:  taken = (op1 == op2);
      BR_BNE:  taken = (op1 != op2);
      BR_BLEZ: taken = op1[DATA_W-1] || (op1 == '0);
      BR_BGTZ: taken = !op1[DATA_W-1] && (op1 != '0);
      BR_J: begin
        taken        = 1'b1;
        target       = pc4;
        target[27:0] = {if_inst[25:0], 2'b00};
      end
      BR_JR: begin
        taken  = 1'b1;
        target = op1;
      end
      default: taken = 1'b0;
    endcase
  end

  logic accept;
  // flush also blocks accept, so a flushed branch can never raise redirect.
  assign if_ready = (state == EMPTY || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;
  assign ex_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    if (flush)         state_nxt = EMPTY;
    else if (accept)   state_nxt = FULL;
    else if (ex_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Payload only loads on accept, which keeps ex_* stable while EX stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_aluop      <= ALU_ADD;
      ex_src1       <= '0;
      ex_src2       <= '0;
      ex_store_data <= '0;
      ex_pc         <= '0;
      ex_waddr      <= '0;
      ex_wreg       <= 1'b0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_illegal    <= 1'b0;
      redirect      <= 1'b0;
      redirect_pc   <= '0;
    end else begin
      if (accept) begin
        ex_aluop      <= aluop;
        ex_src1       <= src1;
        ex_src2       <= src2;
        ex_store_data <= op2;
        ex_pc         <= if_pc;
        ex_waddr      <= waddr;
        ex_wreg       <= wreg;
        ex_mem_rd     <= mem_rd;
        ex_mem_wr     <= mem_wr;
        ex_illegal    <= illegal;
      end
      redirect <= accept && taken;
      if (accept && taken) redirect_pc <= target;
    end
  end

endmodule

// File: doc/id_stage.md
# id_stage

Pipelined MIPS instruction-decode stage: successor to the single-cycle decode/execute unit, parametrised in data width and register-file depth. Accepts instructions from fetch over a valid/ready handshake, reads the register file, forwards in-flight results, resolves branches and jumps, and holds one registered decoded instruction for the execute stage. Adds load-use stall, flush, and redirect behaviour that the single-cycle unit does not have.

## Interface
- DATA_W, 32, datapath and PC width
- RADDR_W, 5, register address width (2**RADDR_W registers; register 0 reads as zero)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_valid / if_ready  in / out  1  fetch handshake
- if_inst  in  32  instruction word; if_pc  in  DATA_W  its address
- rf_raddr1 / rf_raddr2  out  RADDR_W  register-file read addresses (rs, rt), combinational from if_inst
- rf_rdata1 / rf_rdata2  in  DATA_W  register-file read data, same cycle
- ex_fwd_wen, ex_fwd_load  in  1; ex_fwd_waddr  in  RADDR_W; ex_fwd_wdata  in  DATA_W  EX-stage result
- mem_fwd_wen  in  1; mem_fwd_waddr  in  RADDR_W; mem_fwd_wdata  in  DATA_W  MEM-stage result
- ex_valid / ex_ready  out / in  1  execute handshake
- ex_aluop  out  alu_op_t; ex_src1, ex_src2, ex_store_data, ex_pc  out  DATA_W
- ex_waddr  out  RADDR_W; ex_wreg, ex_mem_rd, ex_mem_wr, ex_illegal  out  1
- flush  in  1  discard decoded and held instruction
- redirect  out  1; redirect_pc  out  DATA_W  branch/jump target to fetch

## Operation
- Output register states EMPTY / FULL. Accept when if_valid && if_ready; if_ready = (EMPTY || ex_ready) && !load_use && !flush.
- EMPTY→FULL on accept; FULL→EMPTY on ex_ready without accept; FULL stays FULL on ex_ready with accept; flush → EMPTY regardless.
- Operand select per source, priority: reg 0 → 0; EX match (ex_fwd_wen, addr equal, !ex_fwd_load) → ex_fwd_wdata; MEM match → mem_fwd_wdata; else rf_rdata.
- load_use: ex_fwd_wen && ex_fwd_load && ex_fwd_waddr≠0 && equals a source the instruction reads. Stall: if_ready=0, no accept.
- Immediates: sign-extend for ADDI, ADDIU, SLTI, SLTIU, LW, SW; zero-extend for ANDI, ORI, XORI; LUI = imm<<16. SLT/SLTI signed compare, SLTU/SLTIU unsigned; SUB uses true subtraction; shift amount = low 5 bits.
- Branches BEQ/BNE/BLEZ/BGTZ resolved on forwarded operands; target = pc+4 + (sext(imm)<<2). J/JAL target = {pc+4[31:28], imm26, 00}; JR/JALR target = rs. No delay slot. JAL/JALR link = pc+4 into r31 / rd.
- redirect asserted for one cycle, registered, on the cycle after a taken branch/jump is accepted; decoded branch still passes to EX as a no-write bubble (JAL/JALR write link).
- Unknown opcode/funct: ex_illegal=1, ex_wreg=ex_mem_rd=ex_mem_wr=0.

## Timing
- Latency 1 cycle: accept at edge N → ex_valid from N.
- Reset: ex_valid=0, redirect=0, all ex_* and redirect_pc = 0; if_ready follows its equation (1 after reset).
- ex_* stable while ex_valid && !ex_ready.
- flush and accept in same cycle: flush wins, instruction dropped, redirect suppressed.
- Reset mid-stall or mid-redirect: state cleared the following edge.

## Configuration
- ID_FORWARD_EN defined: forwarding as above, stall only on load-use.
- Undefined: no forwarding muxes; any EX or MEM write match (addr≠0) to a used source stalls; ex_fwd_wdata/mem_fwd_wdata ignored.

## Structure
- mips_pkg: opcode and funct localparams, alu_op_t enum, REG_LINK=31.
- Sub-module inst_decoder: combinational if_inst → control bits, immediate kind, source-use flags, branch kind.

## Test plan
- ADDI r1,r0,5 then ADD r2,r1,r1 with EX forward r1=5 -> ex_src1=ex_src2=5, no stall.
- LW r3 in EX (ex_fwd_load=1, waddr=3) then ADD r4,r3,r0 -> if_ready=0 one cycle, ex_valid=0 that cycle.
- BEQ r1,r2,+4 at pc 0x100, both 7 -> redirect=1 one cycle, redirect_pc=0x114.
- ex_ready low 3 cycles while FULL -> ex_* unchanged, if_ready=0.
- JAL 0x40 at pc 0x200 -> ex_waddr=31, ex_src1=0x204, redirect_pc=0x100.
- flush with if_valid=1 -> next cycle ex_valid=0, redirect=0.
